// File: rtl/ysyx_22050039_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// LS wins by default; a streak counter hands the port to a waiting IF after MAX_LS_STREAK LS grants.
module ysyx_22050039_mem_arbiter #(
    parameter int XLEN          = 64,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,

    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_resp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,

    output logic            busy,
    output logic [1:0]      owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_IF     = 2'b01;
    localparam logic [1:0] OWN_LS     = 2'b10;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t     state;
    state_t     state_next;
    logic [3:0] streak;
    logic       grant_if;
    logic       grant_ls;
    logic       resp_fire;

    // Readies are also gated by rst so nothing looks accepted while reset is held.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && rst) begin
            if (ls_req_valid && !(if_req_valid && streak == STREAK_MAX)) begin
                grant_ls = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = (state == ISSUE);
    assign busy          = (state != IDLE);

    // A response in ISSUE only counts once the request itself is accepted.
    assign resp_fire = mem_resp_valid &&
                       ((state == WAIT) || (state == ISSUE && mem_req_ready));

    assign if_resp_valid = resp_fire && (owner == OWN_IF);
    assign ls_resp_valid = resp_fire && (owner == OWN_LS);
    assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
    assign ls_resp_data  = (ls_resp_valid && !mem_wen) ? mem_resp_data : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_ls || grant_if) state_next = ISSUE;
            end
            ISSUE: begin
                if (mem_req_ready) state_next = mem_resp_valid ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= OWN_NONE;
            streak    <= 4'd0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= 8'd0;
        end else if (grant_ls) begin
            owner     <= OWN_LS;
            mem_addr  <= ls_addr;
            mem_wen   <= ls_wen;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            if (!if_req_valid) begin
                streak <= 4'd0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
            end
        end else if (grant_if) begin
            owner     <= OWN_IF;
            mem_addr  <= if_addr;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= 8'd0;
            streak    <= 4'd0;
        end else if (resp_fire) begin
            owner <= OWN_NONE;
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Bench for ysyx_22050039_mem_arbiter: table of single transactions plus hand-written
// reset, starvation and same-cycle response sequences, responses checked through a scoreboard.
module tb_ysyx_22050039_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
    logic [63:0] ls_addr, ls_wdata, ls_resp_data;
    logic [7:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_resp_data;
    logic [7:0]  mem_wmask;
    logic        busy;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ifv;
        logic        lsv;
        logic        wen;
        logic [63:0] if_addr;
        logic [63:0] ls_addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          rdy_delay;
        int          resp_delay;
        logic [1:0]  exp_owner;
    } vec_t;

    typedef struct {
        logic [1:0]  owner;
        logic [63:0] data;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vecs[13];

    ysyx_22050039_mem_arbiter #(.XLEN(64), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ifv, input logic lsv, input logic wen,
                                input logic [63:0] ia, input logic [63:0] la,
                                input logic [63:0] wd, input logic [7:0] wm,
                                input logic [63:0] rd, input int rdl, input int rsl,
                                input logic [1:0] eo);
        vec_t v;
        v.ifv = ifv; v.lsv = lsv; v.wen = wen;
        v.if_addr = ia; v.ls_addr = la; v.wdata = wd; v.wmask = wm;
        v.rdata = rd; v.rdy_delay = rdl; v.resp_delay = rsl; v.exp_owner = eo;
        return v;
    endfunction

    // Response monitor: every resp pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && (if_resp_valid === 1'b1 || ls_resp_valid === 1'b1)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_resp: got if=%b ls=%b required none",
                         if_resp_valid, ls_resp_valid);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("resp_owner", {62'd0, ls_resp_valid, if_resp_valid}, {62'd0, mon_e.owner});
                checkOutput("resp_data", if_resp_valid ? if_resp_data : ls_resp_data, mon_e.data);
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        logic [63:0] e_addr, e_wdata, e_data;
        logic        e_wen;
        logic [7:0]  e_mask;
        if (v.exp_owner == 2'b01) begin
            e_addr = v.if_addr; e_wen = 1'b0; e_wdata = '0; e_mask = 8'd0; e_data = v.rdata;
        end else begin
            e_addr = v.ls_addr; e_wen = v.wen; e_wdata = v.wdata; e_mask = v.wmask;
            e_data = v.wen ? 64'd0 : v.rdata;
        end

        @(posedge clk); #1;
        if_req_valid = v.ifv; if_addr = v.if_addr;
        ls_req_valid = v.lsv; ls_addr = v.ls_addr;
        ls_wen = v.wen; ls_wdata = v.wdata; ls_wmask = v.wmask;
        @(negedge clk);
        checkOutput("grant_if_ready", {63'd0, if_req_ready}, {63'd0, v.exp_owner == 2'b01});
        checkOutput("grant_ls_ready", {63'd0, ls_req_ready}, {63'd0, v.exp_owner == 2'b10});

        for (int c = 0; c <= v.rdy_delay; c++) begin
            @(posedge clk); #1;
            if (c == 0) sb.push_back('{owner: v.exp_owner, data: e_data});
            if (c == 1) begin if_req_valid = 1'b0; ls_req_valid = 1'b0; end
            if (c == v.rdy_delay) begin
                mem_req_ready = 1'b1;
                if (v.resp_delay == 0) begin mem_resp_valid = 1'b1; mem_resp_data = v.rdata; end
            end
            @(negedge clk);
            checkOutput("issue_valid", {63'd0, mem_req_valid}, 64'd1);
            checkOutput("issue_addr", mem_addr, e_addr);
            checkOutput("issue_wen", {63'd0, mem_wen}, {63'd0, e_wen});
            checkOutput("issue_wdata", mem_wdata, e_wdata);
            checkOutput("issue_wmask", {56'd0, mem_wmask}, {56'd0, e_mask});
            checkOutput("issue_owner", {62'd0, owner}, {62'd0, v.exp_owner});
            checkOutput("issue_busy", {63'd0, busy}, 64'd1);
            checkOutput("issue_no_ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
        end

        @(posedge clk); #1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        for (int d = 1; d <= v.resp_delay; d++) begin
            if (d == v.resp_delay) begin mem_resp_valid = 1'b1; mem_resp_data = v.rdata; end
            @(negedge clk);
            checkOutput("wait_valid", {63'd0, mem_req_valid}, 64'd0);
            checkOutput("wait_busy", {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0; mem_resp_data = '0;
        end
        @(negedge clk);
        checkOutput("done_busy", {63'd0, busy}, 64'd0);
        checkOutput("done_owner", {62'd0, owner}, 64'd0);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 1, 64'h8000_0000, 64'h0, 64'h1234, 8'h3C, 64'h00000413_00100073, 0, 1, 2'b01);
        vecs[1]  = mk(1, 1, 0, 64'h8000_0004, 64'h8000_1000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0, 1, 2'b10);
        vecs[2]  = mk(1, 0, 0, 64'h8000_0004, 64'h0, 64'h0, 8'h00, 64'h0000_0013_0000_0013, 0, 1, 2'b01);
        vecs[3]  = mk(0, 1, 1, 64'h0, 64'h8000_0008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 2'b10);
        vecs[4]  = mk(0, 1, 0, 64'h0, 64'h8000_0010, 64'h0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0, 2'b10);
        vecs[5]  = mk(1, 1, 1, 64'h8000_0020, 64'h8000_2000, 64'h0102_0304_0506_0708, 8'h0F, 64'hBAD, 1, 2, 2'b10);
        vecs[6]  = mk(1, 1, 0, 64'h8000_0020, 64'h8000_2008, 64'h0, 8'h00, 64'h6666, 0, 0, 2'b10);
        vecs[7]  = mk(1, 1, 0, 64'h8000_0020, 64'h8000_2010, 64'h0, 8'h00, 64'h7777, 0, 1, 2'b10);
        vecs[8]  = mk(1, 1, 0, 64'h8000_0020, 64'h8000_2018, 64'h0, 8'h00, 64'h8888, 2, 0, 2'b10);
        vecs[9]  = mk(1, 1, 0, 64'h8000_0020, 64'h8000_2020, 64'h0, 8'h00, 64'h9999, 0, 1, 2'b01);
        vecs[10] = mk(1, 1, 0, 64'h8000_0024, 64'h8000_2028, 64'h0, 8'h00, 64'hAAAA, 0, 0, 2'b10);
        vecs[11] = mk(0, 1, 0, 64'h0, 64'h8000_2030, 64'h0, 8'h00, 64'hBBBB, 0, 1, 2'b10);
        vecs[12] = mk(1, 1, 0, 64'h8000_0028, 64'h8000_2038, 64'h0, 8'h00, 64'hCCCC, 0, 1, 2'b10);

        rst = 1'b0;
        if_req_valid = 1'b1; if_addr = 64'h8000_0000;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_owner", {62'd0, owner}, 64'd0);
        checkOutput("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
        checkOutput("rst_mem_addr", mem_addr, 64'd0);
        checkOutput("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; if_req_valid = 1'b0;

        for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

        // Reset while the arbiter waits on memory: transaction abandoned, late response ignored.
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0100;
        @(posedge clk); #1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        checkOutput("midwait_busy", {63'd0, busy}, 64'd1);
        checkOutput("midwait_owner", {62'd0, owner}, 64'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_owner", {62'd0, owner}, 64'd0);
        checkOutput("midrst_mem_addr", mem_addr, 64'd0);
        checkOutput("midrst_if_ready", {63'd0, if_req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge clk);
        checkOutput("late_resp_if", {63'd0, if_resp_valid}, 64'd0);
        checkOutput("late_resp_ls", {63'd0, ls_resp_valid}, 64'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        @(negedge clk);
        checkOutput("late_resp_idle", {63'd0, busy}, 64'd0);

        // Both requesters held high against zero-latency memory: LS x4 then IF, back to back.
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0200;
        ls_req_valid = 1'b1; ls_addr = 64'h8000_3000; ls_wen = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h5555_AAAA_1234_5678;
        for (int k = 0; k < 10; k++) begin
            logic exp_ls;
            exp_ls = ((k % 5) != 4);
            @(negedge clk);
            checkOutput($sformatf("starve_ls_ready_%0d", k), {63'd0, ls_req_ready}, {63'd0, exp_ls});
            checkOutput($sformatf("starve_if_ready_%0d", k), {63'd0, if_req_ready}, {63'd0, !exp_ls});
            @(posedge clk); #1;
            sb.push_back('{owner: exp_ls ? 2'b10 : 2'b01, data: 64'h5555_AAAA_1234_5678});
            @(posedge clk); #1;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050039_mem_arbiter.md
Name: ysyx_22050039_mem_arbiter

Overview:
- Arbitrates the single physical memory port between instruction fetch (IF) and load/store (LS).
- Sits between the fetch/execute datapath and the pmem DPI bridge, so one memory access is in flight at a time.
- Sequences each access as: accept request → issue to memory → wait for response → return it to the owner.
- LS has priority; a streak counter prevents IF starvation.

Parameters:
- XLEN, 64, address/data width
- MAX_LS_STREAK, 4, max consecutive LS grants while IF is waiting; range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_valid  in  1  IF request pending
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  XLEN  IF read address
- if_resp_valid  out  1  IF read data valid, 1-cycle pulse
- if_resp_data  out  XLEN  IF read data
- ls_req_valid  in  1  LS request pending
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  XLEN  LS address
- ls_wen  in  1  1=write, 0=read
- ls_wdata  in  XLEN  write data
- ls_wmask  in  8  byte write mask
- ls_resp_valid  out  1  LS completion, 1-cycle pulse; also acknowledges writes
- ls_resp_data  out  XLEN  LS read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  XLEN  registered write data
- mem_wmask  out  8  registered mask
- mem_resp_valid  in  1  memory response/ack
- mem_resp_data  in  XLEN  memory read data
- busy  out  1  state != IDLE
- owner  out  2  00 none, 01 IF, 10 LS

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (rst=0, asynchronous):
  - State forced to IDLE; streak counter and owner cleared to 0.
  - Captured addr/wen/wdata/wmask registers cleared to 0.
  - All outputs 0.
  - Any in-flight transaction is abandoned.
- IDLE arbitration (combinational):
  - Grant LS if ls_req_valid, unless if_req_valid and streak==MAX_LS_STREAK; in that case grant IF.
  - Otherwise grant IF if if_req_valid.
  - The winner's *_req_ready is 1 in the same cycle; the loser's is 0. ready is never 1 outside IDLE.
- On grant:
  - Capture addr/wen/wdata/wmask.
  - IF grants always have wen=0, wdata=0, wmask=0.
  - Set owner; go to ISSUE.
- Streak counter:
  - On an LS grant with if_req_valid=1: streak+1, saturating at MAX_LS_STREAK.
  - On an IF grant: streak cleared to 0.
  - On an LS grant with if_req_valid=0: streak cleared to 0.
- ISSUE:
  - mem_req_valid=1 with the captured fields, held stable until mem_req_ready=1, then go to WAIT.
  - If mem_req_ready and mem_resp_valid are both 1 in the same ISSUE cycle, the response is accepted in that cycle and the FSM goes straight to IDLE.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: the owner's resp_valid=1 and resp_data=mem_resp_data, combinational passthrough in that cycle.
  - For writes, ls_resp_data=0.
  - Then go to IDLE and clear owner.
- Minimum latency: grant at cycle N, mem_req_valid at N+1, response to requester at N+1 (zero-latency memory) or later. Back-to-back requests are accepted in IDLE the cycle after the response.
- mem_resp_valid in IDLE is ignored: no resp pulse is produced, and the state is unchanged.
- Requesters may drop *_req_valid before ready is asserted; nothing is captured in that case.
- Non-owner resp_valid is always 0; resp_data is 0 when its resp_valid is 0.

Test Plan:
- IF only: if_addr=0x8000_0000, memory ready immediately, resp 1 cycle later with 0x00000413_00100073 → if_req_ready at cycle 0, mem_req_valid at cycle 1, if_resp_valid pulse at cycle 2 with that data, busy 1 for 2 cycles.
- Simultaneous IF+LS read (ls_addr=0x8000_1000) → LS granted first (owner=10), IF served on the next IDLE; no overlap of mem_req_valid.
- LS write: addr=0x8000_0008, wdata=0xDEADBEEF_CAFEF00D, wmask=0xFF, mem_req_ready delayed 3 cycles → mem fields stable for all 3 cycles; ls_resp_valid on ack with ls_resp_data=0.
- Starvation: ls_req_valid and if_req_valid held high continuously, MAX_LS_STREAK=4 → grant sequence LS,LS,LS,LS,IF,LS,… repeating.
- Reset mid-WAIT: rst low during WAIT → outputs 0 immediately, owner=00; a late mem_resp_valid after rst goes high produces no if/ls resp pulse.
- Same-cycle ready+resp in ISSUE → response forwarded in that cycle, FSM back in IDLE next cycle, next request granted then.
